// File: rtl/render_pkg.sv
// Shared constants and helpers for the ball renderer: 640x480@60 VGA timing,
// default playfield geometry and colours, and the per-ball circle hit test.
package render_pkg;

    // Horizontal timing in pixel ticks
    localparam logic [9:0] H_VIS        = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_TOT        = 10'd800;
    localparam logic [9:0] H_LAST       = H_TOT - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing in lines
    localparam logic [9:0] V_VIS        = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_TOT        = 10'd525;
    localparam logic [9:0] V_LAST       = V_TOT - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Default playfield rectangle and colours
    localparam logic [10:0] PF_LEFT_DEF   = 11'd160;
    localparam logic [10:0] PF_TOP_DEF    = 11'd0;
    localparam logic [10:0] PF_W_DEF      = 11'd320;
    localparam logic [10:0] PF_H_DEF      = 11'd480;
    localparam logic [11:0] BALL0_RGB_DEF = 12'hF00;
    localparam logic [11:0] BALL1_RGB_DEF = 12'h0F0;
    localparam logic [11:0] PF_RGB_DEF    = 12'h001;
    localparam logic [11:0] BORDER_RGB    = 12'hFFF;

    // Unsigned distance between two 10-bit coordinates
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Filled-circle test. The box check runs first so the squares only ever
    // see 6-bit operands (dx, dy <= r <= 63); the inclusive compare lets
    // radius 0 hit exactly the centre pixel.
    function automatic logic ball_hit(input logic [9:0] dx, input logic [9:0] dy,
                                      input logic [5:0] r, input logic active);
        logic        w_in_box;
        logic [11:0] w_dx2;
        logic [11:0] w_dy2;
        logic [11:0] w_r2;
        logic [12:0] w_sum;
        w_in_box = (dx <= {4'b0, r}) && (dy <= {4'b0, r});
        w_dx2    = {6'b0, dx[5:0]} * {6'b0, dx[5:0]};
        w_dy2    = {6'b0, dy[5:0]} * {6'b0, dy[5:0]};
        w_r2     = {6'b0, r} * {6'b0, r};
        w_sum    = {1'b0, w_dx2} + {1'b0, w_dy2};
        return active && w_in_box && (w_sum <= {1'b0, w_r2});
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// VGA raster counters for 640x480@60. Produces the current pixel position,
// the raw (unregistered, active-low) sync levels, the visible flag and the
// once-per-frame snapshot strobe at (h=0, v=480). Everything advances only
// on i_pix_tick.
module vga_sync_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_pix_tick,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_visible,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_snap
);
    import render_pkg::*;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    // Raster position: h wraps at end of line and steps v, v wraps at end of frame
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (i_pix_tick) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= 10'd0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    assign o_h_cnt   = r_h_cnt;
    assign o_v_cnt   = r_v_cnt;
    assign o_visible = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_hsync_n = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
    assign o_vsync_n = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
    assign o_snap    = i_pix_tick && (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS);

endmodule

// File: rtl/ball_renderer.sv
// Ball renderer: snapshots the two ball positions, radius and active mask
// once per frame (first tick of line 480), then rasterises each ball as a
// filled circle clipped to the playfield. Two-tick pipeline: S1 holds the
// per-ball distances and pixel flags, S2 holds rgb and both syncs so colour
// and sync leave aligned.
// Build option BALL_RENDER_BORDER_EN draws the 1-pixel playfield perimeter
// in white, below both balls and above the playfield background.
module ball_renderer
    import render_pkg::*;
#(
    parameter logic [10:0] PF_LEFT   = PF_LEFT_DEF,
    parameter logic [10:0] PF_TOP    = PF_TOP_DEF,
    parameter logic [10:0] PF_W      = PF_W_DEF,
    parameter logic [10:0] PF_H      = PF_H_DEF,
    parameter logic [11:0] BALL0_RGB = BALL0_RGB_DEF,
    parameter logic [11:0] BALL1_RGB = BALL1_RGB_DEF,
    parameter logic [11:0] PF_RGB    = PF_RGB_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic [5:0]  radius,
    input  logic [9:0]  bx1,
    input  logic [9:0]  by1,
    input  logic [9:0]  bx2,
    input  logic [9:0]  by2,
    input  logic [1:0]  b_active,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    logic [9:0]  w_h_cnt;
    logic [9:0]  w_v_cnt;
    logic        w_visible;
    logic        w_hsync_n;
    logic        w_vsync_n;
    logic        w_snap;

    vga_sync_gen u_sync (
        .clock      (clock),
        .reset      (reset),
        .i_pix_tick (pix_tick),
        .o_h_cnt    (w_h_cnt),
        .o_v_cnt    (w_v_cnt),
        .o_visible  (w_visible),
        .o_hsync_n  (w_hsync_n),
        .o_vsync_n  (w_vsync_n),
        .o_snap     (w_snap)
    );

    // Offsets into the playfield; 11-bit wrap turns "left of / above" into a
    // large value so a single less-than covers both edges.
    logic [10:0] w_px_off;
    logic [10:0] w_py_off;
    logic        w_in_pf;
    assign w_px_off = {1'b0, w_h_cnt} - PF_LEFT;
    assign w_py_off = {1'b0, w_v_cnt} - PF_TOP;
    assign w_in_pf  = (w_px_off < PF_W) && (w_py_off < PF_H);

    // Shadow copy of the ball state used for the whole frame
    logic [9:0] r_sbx0, r_sby0, r_sbx1, r_sby1;
    logic [5:0] r_srad;
    logic [1:0] r_sact;
    logic       r_frame_start;

    // Snapshot inputs once per frame and flag it for one clock
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sbx0        <= 10'd0;
            r_sby0        <= 10'd0;
            r_sbx1        <= 10'd0;
            r_sby1        <= 10'd0;
            r_srad        <= 6'd0;
            r_sact        <= 2'b00;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap;
            if (w_snap) begin
                r_sbx0 <= bx1;
                r_sby0 <= by1;
                r_sbx1 <= bx2;
                r_sby1 <= by2;
                r_srad <= radius;
                r_sact <= b_active;
            end
        end
    end

    // S1 state: per-ball distances and pixel classification
    logic [9:0] r_dx0, r_dy0, r_dx1, r_dy1;
    logic       r_s1_vis;
    logic       r_s1_in_pf;
    logic       r_s1_hsync_n;
    logic       r_s1_vsync_n;

`ifdef BALL_RENDER_BORDER_EN
    logic w_on_border;
    logic r_s1_border;
    assign w_on_border = w_in_pf && ((w_px_off == 11'd0) || (w_px_off == PF_W - 11'd1) ||
                                     (w_py_off == 11'd0) || (w_py_off == PF_H - 11'd1));

    // Border flag travels with the rest of S1
    always_ff @(posedge clock) begin
        if (reset)         r_s1_border <= 1'b0;
        else if (pix_tick) r_s1_border <= w_on_border;
    end
`endif

    // S1: register distances to each ball centre and the raw pixel flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dx0        <= 10'd0;
            r_dy0        <= 10'd0;
            r_dx1        <= 10'd0;
            r_dy1        <= 10'd0;
            r_s1_vis     <= 1'b0;
            r_s1_in_pf   <= 1'b0;
            r_s1_hsync_n <= 1'b1;
            r_s1_vsync_n <= 1'b1;
        end else if (pix_tick) begin
            r_dx0        <= abs_diff(w_h_cnt, r_sbx0);
            r_dy0        <= abs_diff(w_v_cnt, r_sby0);
            r_dx1        <= abs_diff(w_h_cnt, r_sbx1);
            r_dy1        <= abs_diff(w_v_cnt, r_sby1);
            r_s1_vis     <= w_visible;
            r_s1_in_pf   <= w_in_pf;
            r_s1_hsync_n <= w_hsync_n;
            r_s1_vsync_n <= w_vsync_n;
        end
    end

    // Hit tests; the playfield term clips balls at its edges
    logic w_hit0;
    logic w_hit1;
    assign w_hit0 = r_s1_in_pf && ball_hit(r_dx0, r_dy0, r_srad, r_sact[0]);
    assign w_hit1 = r_s1_in_pf && ball_hit(r_dx1, r_dy1, r_srad, r_sact[1]);

    // Colour priority: blank, ball 0, ball 1, (border), playfield, black
    logic [11:0] w_rgb;
    always_comb begin
        w_rgb = 12'h000;
        if (r_s1_vis) begin
            if (w_hit0)          w_rgb = BALL0_RGB;
            else if (w_hit1)     w_rgb = BALL1_RGB;
`ifdef BALL_RENDER_BORDER_EN
            else if (r_s1_border) w_rgb = BORDER_RGB;
`endif
            else if (r_s1_in_pf) w_rgb = PF_RGB;
        end
    end

    logic [11:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;

    // S2: register colour and syncs together so they stay aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (pix_tick) begin
            r_rgb   <= w_rgb;
            r_hsync <= r_s1_hsync_n;
            r_vsync <= r_s1_vsync_n;
        end
    end

    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_ball_renderer.sv
// Bench for ball_renderer. A raster model counts pixel ticks since reset,
// derives each pixel's colour from circle/rectangle geometry and predicts
// rgb/hsync/vsync/frame_start two ticks later; one negedge process compares
// every cycle and also checks literal colours at chosen pixels.
module tb_ball_renderer;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_tick;
    logic [5:0]  radius;
    logic [9:0]  bx1, by1, bx2, by2;
    logic [1:0]  b_active;
    logic        hsync, vsync, frame_start;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;

    localparam int WAIT_MAX = 700000;

    always #5 clock = ~clock;

    ball_renderer dut (
        .clock       (clock),
        .reset       (reset),
        .pix_tick    (pix_tick),
        .radius      (radius),
        .bx1         (bx1),
        .by1         (by1),
        .bx2         (bx2),
        .by2         (by2),
        .b_active    (b_active),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    // ---------------- model ----------------
    typedef struct packed {
        int          x;
        int          y;
        int          fr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } pix_t;

    int   k = 0;
    int   m_sx0 = 0, m_sy0 = 0, m_sx1 = 0, m_sy1 = 0, m_r = 0;
    logic [1:0] m_act = 2'b00;
    int   m_frames = 0;
    pix_t m_s1, m_out;
    logic m_fs = 1'b0;

    function automatic logic [11:0] exp_colour(input int x, input int y);
        bit in_pf, h0, h1;
        if (x >= 640 || y >= 480) return 12'h000;
        in_pf = (x >= 160) && (x < 480) && (y >= 0) && (y < 480);
        h0 = in_pf && m_act[0] && ((x-m_sx0)*(x-m_sx0) + (y-m_sy0)*(y-m_sy0) <= m_r*m_r);
        h1 = in_pf && m_act[1] && ((x-m_sx1)*(x-m_sx1) + (y-m_sy1)*(y-m_sy1) <= m_r*m_r);
        if (h0) return 12'hF00;
        if (h1) return 12'h0F0;
`ifdef BALL_RENDER_BORDER_EN
        if (in_pf && (x == 160 || x == 479 || y == 0 || y == 479)) return 12'hFFF;
`endif
        if (in_pf) return 12'h001;
        return 12'h000;
    endfunction

    function automatic pix_t idle_pix();
        pix_t p;
        p.x = -1; p.y = -1; p.fr = -1; p.rgb = 12'h000; p.hs = 1'b1; p.vs = 1'b1;
        return p;
    endfunction

    initial begin
        m_s1  = idle_pix();
        m_out = idle_pix();
    end

    // Advance the model on each clock edge that the DUT sees
    always @(posedge clock) begin
        int x, y;
        if (reset) begin
            k = 0; m_frames = 0;
            m_sx0 = 0; m_sy0 = 0; m_sx1 = 0; m_sy1 = 0; m_r = 0; m_act = 2'b00;
            m_s1 = idle_pix(); m_out = idle_pix(); m_fs = 1'b0;
        end else if (pix_tick) begin
            x = k % 800;
            y = (k / 800) % 525;
            m_out    = m_s1;
            m_s1.x   = x;
            m_s1.y   = y;
            m_s1.fr  = m_frames;
            m_s1.rgb = exp_colour(x, y);
            m_s1.hs  = !(x >= 656 && x < 752);
            m_s1.vs  = !(y >= 490 && y < 492);
            m_fs     = (x == 0 && y == 480);
            if (m_fs) begin
                m_sx0 = int'(bx1); m_sy0 = int'(by1);
                m_sx1 = int'(bx2); m_sy1 = int'(by2);
                m_r   = int'(radius); m_act = b_active;
                m_frames++;
            end
            k++;
        end else begin
            m_fs = 1'b0;
        end
    end

    // ---------------- spot table ----------------
    int          sp_n = 0;
    int          sp_fr[24], sp_x[24], sp_y[24];
    logic [11:0] sp_rgb[24];
    bit          sp_seen[24];

    task automatic add_spot(input int fr, input int x, input int y, input logic [11:0] c);
        sp_fr[sp_n] = fr; sp_x[sp_n] = x; sp_y[sp_n] = y; sp_rgb[sp_n] = c;
        sp_seen[sp_n] = 1'b0;
        sp_n++;
    endtask

    // ---------------- compare process ----------------
    int   clk_n = 0;
    int   fs_cnt = 0;
    int   hs_run = 0, vs_run = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    always @(negedge clock) begin
        checks++;
        if (rgb !== m_out.rgb || hsync !== m_out.hs || vsync !== m_out.vs || frame_start !== m_fs) begin
            errors++;
            if (errors <= 20)
                $display("FAIL raster pix(%0d,%0d) fr%0d: got rgb=%h hs=%b vs=%b fs=%b, want rgb=%h hs=%b vs=%b fs=%b",
                         m_out.x, m_out.y, m_out.fr, rgb, hsync, vsync, frame_start,
                         m_out.rgb, m_out.hs, m_out.vs, m_fs);
        end

        for (int i = 0; i < sp_n; i++) begin
            if (m_out.fr == sp_fr[i] && m_out.x == sp_x[i] && m_out.y == sp_y[i]) begin
                sp_seen[i] = 1'b1;
                checks++;
                if (rgb !== sp_rgb[i]) begin
                    errors++;
                    $display("FAIL spot(%0d,%0d) fr%0d: got rgb=%h want %h",
                             sp_x[i], sp_y[i], sp_fr[i], rgb, sp_rgb[i]);
                end
            end
        end

        if (!reset) begin
            clk_n++;
            if (frame_start === 1'b1 && clk_n <= 420000) fs_cnt++;
            if (clk_n == 420000) begin
                checks++;
                if (fs_cnt != 1) begin
                    errors++;
                    $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
                end
            end

            if (hsync === 1'b0) hs_run++;
            else begin
                if (hs_prev === 1'b0) begin
                    checks++;
                    if (hs_run != 96) begin
                        errors++;
                        $display("FAIL hsync_width: got %0d want 96", hs_run);
                    end
                end
                hs_run = 0;
            end
            if (vsync === 1'b0) vs_run++;
            else begin
                if (vs_prev === 1'b0) begin
                    checks++;
                    if (vs_run != 1600) begin
                        errors++;
                        $display("FAIL vsync_width: got %0d want 1600", vs_run);
                    end
                end
                vs_run = 0;
            end
            hs_prev = hsync;
            vs_prev = vsync;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_pix(input int fr, input int x, input int y);
        int n;
        n = 0;
        while (!(m_out.fr == fr && m_out.x == x && m_out.y == y) && n < WAIT_MAX) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= WAIT_MAX) begin
            errors++;
            $display("FAIL wait_pix(%0d,%0d) fr%0d: timed out after %0d cycles", x, y, fr, n);
        end
    endtask

    initial begin
        // frame 0: shadow still reset
        add_spot(0, 320, 240, 12'h001);
        // frame 1: ball 0 at (320,240) r=8, b_active=01
        add_spot(1, 320, 240, 12'hF00);
        add_spot(1, 328, 240, 12'hF00);
        add_spot(1, 329, 240, 12'h001);
        add_spot(1, 326, 246, 12'h001);
        add_spot(1, 320, 232, 12'hF00);
        add_spot(1, 312, 240, 12'hF00);
        add_spot(1, 400, 240, 12'h001);
        add_spot(1, 159, 10,  12'h000);
`ifdef BALL_RENDER_BORDER_EN
        add_spot(1, 160, 10,  12'hFFF);
`else
        add_spot(1, 160, 10,  12'h001);
`endif
        // frame 2: both balls at (400,240), b_active=11
        add_spot(2, 400, 240, 12'hF00);
        add_spot(2, 408, 240, 12'hF00);
        add_spot(2, 320, 240, 12'h001);
        // frame 3: both balls at (165,240), b_active=10, clipped at x=160
        add_spot(3, 165, 240, 12'h0F0);
        add_spot(3, 160, 240, 12'h0F0);
        add_spot(3, 159, 240, 12'h000);
        add_spot(3, 157, 240, 12'h000);
        add_spot(3, 173, 240, 12'h0F0);
        add_spot(3, 174, 240, 12'h001);
        add_spot(3, 165, 248, 12'h0F0);
        add_spot(3, 165, 249, 12'h001);

        reset    = 1'b1;
        pix_tick = 1'b0;
        radius   = 6'd8;
        bx1 = 10'd320; by1 = 10'd240;
        bx2 = 10'd320; by2 = 10'd240;
        b_active = 2'b01;
        repeat (3) @(negedge clock);
        reset    = 1'b0;
        pix_tick = 1'b1;

        // mid-frame input change: must not affect frame 1
        wait_pix(1, 0, 100);
        bx1 = 10'd400; bx2 = 10'd400; b_active = 2'b11;

        // stall the pixel clock inside ball 0 on line 240
        wait_pix(1, 325, 240);
        pix_tick = 1'b0;
        repeat (100) @(negedge clock);
        pix_tick = 1'b1;

        wait_pix(2, 0, 100);
        bx1 = 10'd165; bx2 = 10'd165; b_active = 2'b10;

        wait_pix(3, 0, 250);

        for (int i = 0; i < sp_n; i++) begin
            checks++;
            if (!sp_seen[i]) begin
                errors++;
                $display("FAIL spot_reached(%0d,%0d) fr%0d: got never want reached", sp_x[i], sp_y[i], sp_fr[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
Display-side consumer of the game state block's ball outputs (two ball centres, radius, active mask). It generates 640x480@60 VGA timing, snapshots ball state once per frame, and rasterises each ball as a filled circle inside the 320x480 playfield. Output is 12-bit RGB plus sync, driving the VGA DAC pins directly.

Parameters:
PF_LEFT, 160, playfield left x (pixels)
PF_TOP, 0, playfield top y
PF_W, 320, playfield width
PF_H, 480, playfield height
BALL0_RGB, 12'hF00, ball 0 colour
BALL1_RGB, 12'h0F0, ball 1 colour
PF_RGB, 12'h001, playfield background colour

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
pix_tick  in  1  pixel-clock enable (25 MHz rate); all state advances only when high
radius  in  6  ball radius (pixels)
bx1, by1  in  10 each  ball 0 centre
bx2, by2  in  10 each  ball 1 centre
b_active  in  2  bit0 = ball 0 drawn, bit1 = ball 1 drawn
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
rgb  out  12  {R[3:0],G[3:0],B[3:0]}
frame_start  out  1  one-clock pulse when the snapshot is taken

Behaviour:
- Reset: h_cnt = v_cnt = 0; hsync = vsync = 1; rgb = 0; frame_start = 0; snapshot regs (positions, radius, active) = 0. Reset mid-frame restarts the raster at (0,0) on the next tick.
- Timing (per pix_tick): h_cnt 0..799 (visible 0..639, sync 656..751); v_cnt 0..524 (visible 0..479, sync 490..491). h_cnt wraps 799->0 and increments v_cnt; v_cnt wraps 524->0.
- When pix_tick is low: counters, pipeline and outputs hold; frame_start stays 0.
- Snapshot: on the tick where h_cnt==0 and v_cnt==480, latch bx/by/radius/b_active into the shadow regs and pulse frame_start for that clock. Input changes at any other time have no effect on the current frame.
- Pipeline, 2 ticks: S1 registers dx = |h_cnt - sbx|, dy = |v_cnt - sby| (10-bit unsigned) per ball, plus visible/in-playfield/raw sync flags. S2 registers rgb, hsync, vsync. Sync and colour stay aligned. hsync first goes low 2 ticks after h_cnt reaches 656.
- Hit test per ball: hit = active && dx <= r && dy <= r && (dx*dx + dy*dy <= r*r). Squares are only formed after the range check (6x6 -> 12 bits; sum 13 bits). Comparison is inclusive.
- Colour priority: outside visible area -> 0; ball 0 hit -> BALL0_RGB; else ball 1 hit -> BALL1_RGB; else inside playfield (PF_LEFT <= x < PF_LEFT+PF_W, PF_TOP <= y < PF_TOP+PF_H) -> PF_RGB; else 0.
- Balls are clipped to the playfield: no hit outside the playfield rectangle.
- radius = 0: only the exact centre pixel is hit.

Optional Feature:
BALL_RENDER_BORDER_EN: when defined, the 1-pixel playfield perimeter (x == PF_LEFT, x == PF_LEFT+PF_W-1, y == PF_TOP, y == PF_TOP+PF_H-1) is drawn 12'hFFF. The border ranks below both balls and above PF_RGB. When undefined, perimeter pixels use the normal priority rules.

Decomposition:
- render_pkg: VGA timing constants (H_VIS 640, H_FP 16, H_SYNC 96, H_TOT 800, V_VIS 480, V_FP 10, V_SYNC 2, V_TOT 525), default playfield and colour constants.
- Sub-module vga_sync_gen: h/v counters, raw sync, visible flag, snapshot strobe.
- ball_renderer instantiates vga_sync_gen and contains the snapshot, hit-test pipeline and colour mux.

Test Plan:
- Reset, pix_tick=1 for 420000 clocks -> exactly one frame_start. hsync low for 96 ticks per line, starting 2 ticks after h_cnt=656. vsync low for 2 lines.
- Ball 0 at (320,240), r=8, b_active=01 -> pixels (320,240) and (328,240) = 12'hF00; (329,240) = 12'h001; (326,246) = 12'h001 (72 > 64).
- Both balls at (320,240), b_active=11 -> overlap pixels = 12'hF00. With b_active=10 -> 12'h0F0.
- Change bx1 from 320 to 400 at v_cnt=100 -> current frame still draws at 320; the next frame draws at 400 after the frame_start pulse.
- pix_tick held low 100 clocks mid-line -> rgb, hsync and vsync unchanged. The raster resumes at the same pixel.
- Ball at (165,240), r=8 -> x=159 is 0 (clipped). With BALL_RENDER_BORDER_EN, pixel (160,10) = 12'hFFF and pixel (160,240) = 12'hF00.
